// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, then drives the register-file write port for one DONE cycle.
module muldiv_unit #(
    parameter int  VALUE_W    = 32,
    parameter int  REG_ADDR_W = 5,
    localparam int CNT_W      = $clog2(VALUE_W) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [VALUE_W-1:0]    operandA,
    input  logic [VALUE_W-1:0]    operandB,
    input  logic [REG_ADDR_W-1:0] rdIn,
    output logic                  busy,
    output logic                  done,
    output logic [VALUE_W-1:0]    result,
    output logic [REG_ADDR_W-1:0] rdOut,
    output logic                  RegWrite
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(VALUE_W - 1);

    state_t                  state;
    op_t                     op_q;
    logic [VALUE_W-1:0]      a_q;
    logic [VALUE_W-1:0]      b_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [CNT_W-1:0]        count;
    // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*VALUE_W-1:0]    acc;

    logic                    is_div;
    logic                    take_high;
    logic [VALUE_W:0]        mul_sum;
    logic [VALUE_W:0]        div_cand;
    logic [VALUE_W:0]        div_diff;
    logic [2*VALUE_W-1:0]    acc_next;

    assign busy      = (state != S_IDLE);
    assign is_div    = (op_q == OP_DIVU) || (op_q == OP_REMU);
    // MULHU and REMU both read the upper half of the accumulator.
    assign take_high = (op_q == OP_MULHU) || (op_q == OP_REMU);

    // NOTE: every signal written here gets a value on every path so no latch is inferred.
    always_comb begin
        mul_sum  = {1'b0, acc[2*VALUE_W-1:VALUE_W]} + (acc[0] ? {1'b0, a_q} : '0);
        div_cand = acc[2*VALUE_W-1:VALUE_W-1];
        div_diff = div_cand - {1'b0, b_q};
        if (is_div) begin
            // Bit VALUE_W of the difference is the borrow: set means divisor did not fit.
            if (div_diff[VALUE_W])
                acc_next = {div_cand[VALUE_W-1:0], acc[VALUE_W-2:0], 1'b0};
            else
                acc_next = {div_diff[VALUE_W-1:0], acc[VALUE_W-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[VALUE_W-1:1]};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: datapath registers are cleared as well, so an aborted operation leaves nothing behind.
            state    <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            count    <= '0;
            acc      <= '0;
            done     <= 1'b0;
            RegWrite <= 1'b0;
            result   <= '0;
            rdOut    <= '0;
        end else begin
            done     <= 1'b0;
            RegWrite <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op_t'(op);
                        a_q   <= operandA;
                        b_q   <= operandB;
                        rd_q  <= rdIn;
                        count <= '0;
                        acc   <= {{VALUE_W{1'b0}}, (op[1] ? operandA : operandB)};
                        if (op[1] && (operandB == '0)) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            RegWrite <= (rdIn != '0);
                            rdOut    <= rdIn;
                            result   <= op[0] ? operandA : '1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        RegWrite <= (rd_q != '0);
                        rdOut    <= rd_q;
                        result   <= take_high ? acc_next[2*VALUE_W-1:VALUE_W]
                                              : acc_next[VALUE_W-1:0];
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model and a register file model.
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  operandA = '0;
    logic [W-1:0]  operandB = '0;
    logic [AW-1:0] rdIn = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [AW-1:0] rdOut;
    logic          RegWrite;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] rf [32];

    muldiv_unit #(.VALUE_W(W), .REG_ADDR_W(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operandA (operandA),
        .operandB (operandB),
        .rdIn     (rdIn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rdOut    (rdOut),
        .RegWrite (RegWrite)
    );

    always #5 clock = ~clock;

    // Register file writes on the falling edge.
    always @(negedge clock) if (RegWrite) rf[rdOut] <= result;

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] rd, input bit keep);
        @(negedge clock);
        op = o; operandA = a; operandB = b; rdIn = rd; start = 1'b1;
        @(posedge clock); #1;
        if (!keep) start = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done; optionally scrambles inputs meanwhile.
    task automatic wait_done(input int budget, input bit scramble, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < budget) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (scramble) begin
                operandA = $urandom; operandB = $urandom; op = 2'($urandom); rdIn = 5'($urandom);
            end
            @(posedge clock); #1;
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [AW-1:0] rd,
                          output logic [W-1:0] res, output logic [AW-1:0] rdo, output logic rw,
                          output int lat, output bit busy_ok,
                          output logic post_done, output logic post_rw, output logic post_busy,
                          output logic [W-1:0] post_res);
        issue(o, a, b, rd, 1'b0);
        wait_done(W + 8, 1'b1, lat, busy_ok);
        res = result; rdo = rdOut; rw = RegWrite;
        @(posedge clock); #1;
        post_done = done; post_rw = RegWrite; post_busy = busy; post_res = result;
    endtask

    task automatic test_reset;
        logic [W-1:0] res, pres;
        logic [AW-1:0] rdo;
        logic rw, pd, prw, pb;
        int lat;
        bit bok, seen;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, RegWrite} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, RegWrite});
        end
        checks++;
        if ({result, rdOut} !== '0) begin
            errors++; $display("FAIL reset_data: got result=%h rdOut=%0d expected 0", result, rdOut);
        end
        @(negedge clock) reset = 1'b1;

        issue(2'b00, 32'd7, 32'd6, 5'd5, 1'b0);
        repeat (8) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, RegWrite, result, rdOut} !== '0) begin
            errors++; $display("FAIL reset_midop_outputs: got busy=%b done=%b rw=%b result=%h rdOut=%0d expected all 0",
                               busy, done, RegWrite, result, rdOut);
        end
        #2 reset = 1'b1;
        seen = 1'b0;
        repeat (W + 8) begin
            @(posedge clock); #1;
            if (done !== 1'b0 || RegWrite !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_abandon: got activity after reset expected none");
        end
        checks++;
        if (rf[5] !== '0) begin
            errors++; $display("FAIL reset_no_write: got rf[5]=%h expected 0", rf[5]);
        end

        run_op(2'b00, 32'd7, 32'd6, 5'd5, res, rdo, rw, lat, bok, pd, prw, pb, pres);
        checks++;
        if (res !== 32'd42 || rw !== 1'b1 || rdo !== 5'd5) begin
            errors++; $display("FAIL reset_rerun: got result=%0d rw=%b rd=%0d expected 42 1 5", res, rw, rdo);
        end
    endtask

    task automatic test_mul_corners;
        logic [W-1:0] res, pres;
        logic [AW-1:0] rdo;
        logic rw, pd, prw, pb;
        int lat;
        bit bok;
        logic [W-1:0] exp_res [2];
        exp_res[0] = 32'h0000_0001;
        exp_res[1] = 32'hFFFF_FFFE;
        for (int i = 0; i < 2; i++) begin
            run_op(2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, res, rdo, rw, lat, bok, pd, prw, pb, pres);
            checks++;
            if (res !== exp_res[i]) begin
                errors++; $display("FAIL mul_max_result op=%0d: got %h expected %h", i, res, exp_res[i]);
            end
            checks++;
            if (lat !== W) begin
                errors++; $display("FAIL mul_latency op=%0d: got %0d edges expected %0d", i, lat, W);
            end
            checks++;
            if (rw !== 1'b1 || rdo !== 5'd3 || bok !== 1'b1) begin
                errors++; $display("FAIL mul_write op=%0d: got rw=%b rd=%0d busy_ok=%b expected 1 3 1", i, rw, rdo, bok);
            end
        end
    endtask

    task automatic test_div_directed;
        logic [W-1:0] res, pres;
        logic [AW-1:0] rdo;
        logic rw, pd, prw, pb;
        int lat;
        bit bok;
        logic [W-1:0] da [3], db [3], eq [3], er [3];
        da[0] = 32'd100;        db[0] = 32'd7; eq[0] = 32'd14;         er[0] = 32'd2;
        da[1] = 32'd5;          db[1] = 32'd9; eq[1] = 32'd0;          er[1] = 32'd5;
        da[2] = 32'h8000_0000;  db[2] = 32'd1; eq[2] = 32'h8000_0000;  er[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            run_op(2'b10, da[i], db[i], 5'd12, res, rdo, rw, lat, bok, pd, prw, pb, pres);
            checks++;
            if (res !== eq[i] || lat !== W) begin
                errors++; $display("FAIL divu_%0d: got %h lat=%0d expected %h lat=%0d", i, res, lat, eq[i], W);
            end
            run_op(2'b11, da[i], db[i], 5'd13, res, rdo, rw, lat, bok, pd, prw, pb, pres);
            checks++;
            if (res !== er[i] || lat !== W) begin
                errors++; $display("FAIL remu_%0d: got %h lat=%0d expected %h lat=%0d", i, res, lat, er[i], W);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [W-1:0] res, pres;
        logic [AW-1:0] rdo;
        logic rw, pd, prw, pb;
        int lat;
        bit bok;
        run_op(2'b10, 32'd123, 32'd0, 5'd6, res, rdo, rw, lat, bok, pd, prw, pb, pres);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 0 || rw !== 1'b1) begin
            errors++; $display("FAIL divu_zero: got %h lat=%0d rw=%b expected ffffffff lat=0 rw=1", res, lat, rw);
        end
        checks++;
        if (pd !== 1'b0 || pb !== 1'b0 || pres !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu_zero_after: got done=%b busy=%b result=%h expected 0 0 ffffffff", pd, pb, pres);
        end
        run_op(2'b11, 32'd123, 32'd0, 5'd6, res, rdo, rw, lat, bok, pd, prw, pb, pres);
        checks++;
        if (res !== 32'd123 || lat !== 0) begin
            errors++; $display("FAIL remu_zero: got %0d lat=%0d expected 123 lat=0", res, lat);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] res, pres, a, b, exp_res;
        logic [AW-1:0] rdo, rd;
        logic [1:0] o;
        logic rw, pd, prw, pb;
        int lat, exp_lat;
        bit bok;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            rd = 5'($urandom);
            exp_res = model(o, a, b);
            exp_lat = (o[1] && b == '0) ? 0 : W;
            run_op(o, a, b, rd, res, rdo, rw, lat, bok, pd, prw, pb, pres);
            checks++;
            if (res !== exp_res) begin
                errors++; $display("FAIL rand_result %0d op=%0d a=%h b=%h: got %h expected %h", n, o, a, b, res, exp_res);
            end
            checks++;
            if (lat !== exp_lat || bok !== 1'b1) begin
                errors++; $display("FAIL rand_timing %0d: got lat=%0d busy_ok=%b expected lat=%0d busy_ok=1", n, lat, bok, exp_lat);
            end
            checks++;
            if (rdo !== rd || rw !== (rd != '0)) begin
                errors++; $display("FAIL rand_write %0d: got rd=%0d rw=%b expected rd=%0d rw=%b", n, rdo, rw, rd, rd != '0);
            end
            checks++;
            if (pd !== 1'b0 || prw !== 1'b0 || pb !== 1'b0 || pres !== exp_res) begin
                errors++; $display("FAIL rand_after %0d: got done=%b rw=%b busy=%b result=%h expected 0 0 0 %h",
                                   n, pd, prw, pb, pres, exp_res);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a1, b1, a2, b2;
        int lat;
        bit bok;
        a1 = $urandom; b1 = $urandom;
        issue(2'b00, a1, b1, 5'd4, 1'b1);
        wait_done(W + 8, 1'b1, lat, bok);
        checks++;
        if (result !== model(2'b00, a1, b1) || lat !== W || bok !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %h lat=%0d busy_ok=%b expected %h lat=%0d busy_ok=1",
                               result, lat, bok, model(2'b00, a1, b1), W);
        end
        // Decoy presented during DONE; it must not be taken.
        op = 2'b11; operandA = $urandom; operandB = '0; rdIn = 5'd1;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0 0", busy, done);
        end
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        op = 2'b10; operandA = a2; operandB = b2; rdIn = 5'd7;
        @(posedge clock); #1;
        wait_done(W + 8, 1'b1, lat, bok);
        checks++;
        if (result !== a2 / b2 || rdOut !== 5'd7 || lat !== W || bok !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got %h rd=%0d lat=%0d busy_ok=%b expected %h rd=7 lat=%0d busy_ok=1",
                               result, rdOut, lat, bok, a2 / b2, W);
        end
        start = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_write_x0;
        logic [W-1:0] res, pres;
        logic [AW-1:0] rdo;
        logic rw, pd, prw, pb;
        int lat;
        bit bok;
        run_op(2'b00, 32'd3, 32'd4, 5'd0, res, rdo, rw, lat, bok, pd, prw, pb, pres);
        checks++;
        if (res !== 32'd12 || rw !== 1'b0 || lat !== W) begin
            errors++; $display("FAIL x0_op: got result=%0d rw=%b lat=%0d expected 12 0 %0d", res, rw, lat, W);
        end
        checks++;
        if (rf[0] !== '0) begin
            errors++; $display("FAIL x0_read: got %h expected 0", rf[0]);
        end
        run_op(2'b00, 32'd3, 32'd4, 5'd9, res, rdo, rw, lat, bok, pd, prw, pb, pres);
        checks++;
        if (rf[9] !== 32'd12) begin
            errors++; $display("FAIL x9_read: got %h expected 0000000c", rf[9]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_mul_corners();
        test_div_directed();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_write_x0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read values (read1, read2) plus destination index, runs a shift-add multiply or restoring divide, then drives the register file write port (rd, writeData, RegWrite) for one cycle.
- Decode stalls issue while busy is high.

Parameters:
- VALUE_W, 32, operand/result width; must be a power of two, minimum 4.
- REG_ADDR_W, 5, register index width.
- CNT_W, $clog2(VALUE_W)+1, iteration counter width; derived, never overridden.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low.
- start  input  1  issue request; sampled only in IDLE.
- op  input  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
- operandA  input  VALUE_W  multiplicand / dividend (from read1).
- operandB  input  VALUE_W  multiplier / divisor (from read2).
- rdIn  input  REG_ADDR_W  destination register index.
- busy  output  1  high in RUN and DONE; decode holds issue while high.
- done  output  1  one-cycle result-valid strobe.
- result  output  VALUE_W  to register file writeData.
- rdOut  output  REG_ADDR_W  to register file rd.
- RegWrite  output  1  to register file RegWrite.

Behaviour:
- Reset (async, while low): state=IDLE; busy=0, done=0, RegWrite=0, result=0, rdOut=0; counter, accumulator, and operand registers all cleared. Reset mid-RUN abandons the operation; nothing is written.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches op, operandA, operandB, rdIn; counter=0; goes to RUN.
  - Exception: DIVU/REMU with operandB==0 goes directly to DONE.
  - start=0: remain in IDLE.
- RUN: one iteration per cycle, exactly VALUE_W cycles, then DONE.
  - MUL/MULHU: unsigned shift-add over a 2*VALUE_W product register.
  - DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- DONE: exactly one cycle; then IDLE.
  - done=1; RegWrite = (rdOut != 0); result and rdOut valid.
  - The register file writes on the falling edge, so result, rdOut, and RegWrite are registered on the rising edge and held stable for the full DONE cycle.
- Latency: start sampled at edge N; done high during cycle N+VALUE_W+1 (33 cycles for 32-bit). Divide-by-zero: done high during cycle N+1.
- Result selection:
  - MUL = product[VALUE_W-1:0]; MULHU = product[2*VALUE_W-1:VALUE_W].
  - DIVU = quotient; REMU = remainder.
  - Divide by zero: DIVU = all ones; REMU = operandA.
- All arithmetic is unsigned and modulo 2^VALUE_W per word; no overflow flag.
- Handshake rules:
  - start is ignored while busy=1; no queueing.
  - start asserted in the cycle after DONE (state back in IDLE) is accepted normally, giving back-to-back operations with one IDLE cycle between.
  - Inputs only need to be valid in the start cycle.
- Outside DONE: done=0, RegWrite=0. result and rdOut hold their last values (no glitch back to 0).
- rdIn==0: the operation still runs full latency with done=1, but RegWrite=0.

Test Plan:
- Reset mid-op: MUL 7*6 rd=5, reset pulsed low at cycle 10 → all outputs 0 immediately, no RegWrite, returns to IDLE; next MUL 7*6 → result=42.
- MUL/MULHU: 0xFFFFFFFF*0xFFFFFFFF → MUL result=0x00000001, MULHU result=0xFFFFFFFE, done exactly 33 cycles after start, RegWrite=1 with rdOut=rdIn=3.
- DIVU/REMU: 100/7 → DIVU=14, REMU=2; 5/9 → DIVU=0, REMU=5; 0x80000000/1 → DIVU=0x80000000.
- Divide by zero: DIVU 123/0 → 0xFFFFFFFF, REMU 123/0 → 123, done 1 cycle after start.
- Busy and back-to-back: start held high continuously with changing operands → second op accepted only in the IDLE cycle after DONE; mid-RUN operand changes do not affect the result; busy=1 throughout RUN/DONE.
- Write to x0: MUL 3*4 rdIn=0 → done=1, result=12, RegWrite=0; integrated with the register file, a subsequent read of x0 returns 0 and a read of rd=9 after MUL 3*4 rd=9 returns 12.
